// File: rtl/mul_seq.sv
// Iterative shift-and-add unsigned multiplier: one product bit-step per clock,
// fixed DATAWIDTH-cycle latency, truncated product plus overflow flag.
module mul_seq #(
    parameter int DATAWIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] prod,
    output logic                 ovf
);

    localparam int CW = $clog2(DATAWIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]             state;
    logic [2*DATAWIDTH-1:0] mcand;
    logic [2*DATAWIDTH-1:0] acc;
    logic [2*DATAWIDTH-1:0] acc_next;
    logic [DATAWIDTH-1:0]   mpr;
    logic [CW-1:0]          cnt;
    logic                   last;

    always_comb begin
        acc_next = mpr[0] ? acc + mcand : acc;
        last     = (cnt == CW'(DATAWIDTH - 1));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
            ovf   <= 1'b0;
            mcand <= '0;
            mpr   <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= {{DATAWIDTH{1'b0}}, a};
                        mpr   <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mpr   <= mpr >> 1;
                    cnt   <= cnt + 1'b1;
                    // Result registers update only here, so a new start never disturbs them.
                    if (last) begin
                        prod  <= acc_next[DATAWIDTH-1:0];
                        ovf   <= |acc_next[2*DATAWIDTH-1:DATAWIDTH];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed vector table, multi-cycle corner
// sequences and randomized operands against a plain-arithmetic product model.
module tb_mul_seq;

    localparam int DW = 16;

    logic          Clk;
    logic          Rst;
    logic          start;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] prod;
    logic          ovf;

    int n_chk  = 0;
    int n_fail = 0;

    mul_seq #(.DATAWIDTH(DW)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .prod (prod),
        .ovf  (ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] p;
        logic          o;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive a start pulse at a falling edge; start is sampled on the next rising edge.
    task automatic go(input logic [DW-1:0] x, input logic [DW-1:0] y);
        @(negedge Clk);
        a     = x;
        b     = y;
        start = 1'b1;
    endtask

    // lat = falling edges from the start drive until done seen (DW+1 expected).
    task automatic wait_done(output int lat, output int busyc);
        @(negedge Clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = 1;
        busyc = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(negedge Clk);
            lat++;
            if (busy) busyc++;
        end
    endtask

    task automatic run_check(input string nm, input logic [DW-1:0] x, input logic [DW-1:0] y,
                             input logic [DW-1:0] ep, input logic eo, input bit full);
        int lat, busyc;
        go(x, y);
        wait_done(lat, busyc);
        chk({nm, " latency"}, lat, DW + 1);
        chk({nm, " prod"}, prod, ep);
        chk({nm, " ovf"}, ovf, eo);
        if (full) begin
            chk({nm, " busy cycles"}, busyc, DW);
            @(negedge Clk);
            chk({nm, " done one cycle"}, done, 0);
            chk({nm, " prod held"}, prod, ep);
        end
    endtask

    initial begin
        int lat, busyc, dones, bad;
        logic [31:0] full;
        logic [DW-1:0] ra, rb;

        vecs[0] = '{16'd3,    16'd5,    16'h000F, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1};
        vecs[3] = '{16'h0100, 16'h0100, 16'h0000, 1'b1};
        vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'h0000, 16'hBEEF, 16'h0000, 1'b0};
        vecs[6] = '{16'd7,    16'd9,    16'h003F, 1'b0};

        Rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge Clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset prod", prod, 0);
        chk("reset ovf", ovf, 0);
        Rst = 1'b0;

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, 1'b1);

        // Abort mid-run: prod currently 0x3F from the last vector.
        go(16'd7, 16'd9);
        @(negedge Clk);
        start = 1'b0;
        repeat (6) @(negedge Clk);
        chk("abort busy before rst", busy, 1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort prod", prod, 0);
        chk("abort ovf", ovf, 0);
        dones = 0;
        repeat (25) begin
            @(negedge Clk);
            if (done) dones++;
        end
        chk("abort no done", dones, 0);
        run_check("after abort 2*2", 16'd2, 16'd2, 16'd4, 1'b0, 1'b1);

        // Start pulses during RUN must be ignored.
        go(16'h1234, 16'h0000);
        @(negedge Clk);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 3 || k == 8 || k == 13) begin
                a = 16'd5; b = 16'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge Clk);
            if (done) begin
                dones++;
                chk("ignore prod", prod, 0);
                chk("ignore ovf", ovf, 0);
            end
        end
        chk("ignore done count", dones, 1);

        // Back-to-back: start held high across DONE.
        go(16'd10, 16'd10);
        @(negedge Clk);
        a = 16'd20; b = 16'd30;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge Clk);
            lat++;
        end
        chk("b2b first latency", lat, DW + 1);
        chk("b2b first prod", prod, 100);
        @(negedge Clk);
        start = 1'b0;
        a = '0; b = '0;
        chk("b2b done drop", done, 0);
        chk("b2b busy again", busy, 1);
        lat = 1; bad = 0;
        while (!done && lat < 60) begin
            if (prod !== 16'd100) bad++;
            @(negedge Clk);
            lat++;
        end
        chk("b2b prod held", bad, 0);
        chk("b2b gap", lat, DW + 1);
        chk("b2b second prod", prod, 600);
        chk("b2b second ovf", ovf, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            if (i == 0) ra = '1;
            full = 32'(ra) * 32'(rb);
            go(ra, rb);
            wait_done(lat, busyc);
            chk("rand latency", lat, DW + 1);
            chk("rand prod", prod, full[DW-1:0]);
            chk("rand ovf", ovf, (full >> DW) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
